pulse_gen_multi: RTL and testbench
==================================

Name: pulse_gen_multi

Overview:
Multi-channel programmable pulse generator. Each channel has its own period, high-time and mode, programmed at runtime through a valid/ready config port.
- Config updates are shadowed and take effect only at a period boundary, so output waveforms never glitch.
- Sits in the timing/control area and drives strobes and enables to downstream blocks.

Parameters:
- NUM_CH, 4, number of independent channels (>=1)
- CNT_W, 8, width of the period/width counters and config fields
- DEFAULT_PERIOD, 10, per-channel period loaded at reset (cycles)
- DEFAULT_WIDTH, 3, per-channel high-time loaded at reset (cycles)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config accept; combinational = ~pend[cfg_ch]
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel; values >= NUM_CH are accepted and discarded
- cfg_period  in  CNT_W  new period in cycles
- cfg_width  in  CNT_W  new high-time in cycles
- cfg_mode  in  1  0 = continuous, 1 = one-shot
- en  in  NUM_CH  per-channel enable
- trig  in  NUM_CH  per-channel one-shot start, level-sampled
- pulse  out  NUM_CH  pulse outputs, registered
- busy  out  NUM_CH  channel in RUN, registered
- done  out  NUM_CH  1-cycle strobe at end of a one-shot, registered

Behaviour:
- Reset (rst_n low, async), per channel:
  - state=IDLE, count=0
  - period=DEFAULT_PERIOD, width=DEFAULT_WIDTH, mode=0
  - pend=0; pulse=0, busy=0, done=0
- Config handshake:
  - Transfer occurs on cfg_valid && cfg_ready at a rising edge.
  - Fields go to the channel's shadow registers and pend[ch] is set.
  - While pend[ch]=1, cfg_ready=0 for that cfg_ch.
- Shadow apply (shadow→active, pend cleared):
  - In IDLE: on the cycle after the transfer.
  - In RUN: at the period boundary (count==period_eff-1).
- Effective values:
  - period_eff = (period==0) ? 1 : period.
  - width>=period_eff → pulse constantly high while RUN (100%).
  - width==0 → pulse constantly low.
- Per-channel FSM, states IDLE and RUN:
  - IDLE→RUN when en=1 and (mode=0 or trig=1). count loads 0; busy=1 and pulse=(width>0) from the next edge.
  - RUN: count increments each cycle; pulse=(count<width), registered, so it is aligned with count.
  - RUN at count==period_eff-1, mode=0: count wraps to 0, stays in RUN.
  - RUN at count==period_eff-1, mode=1: go IDLE; done=1 for exactly 1 cycle; pulse=0, busy=0.
  - Any state with en=0: next edge forces IDLE, count=0, pulse=0, busy=0, done=0. A pending shadow applies in that same cycle.
- Timing example: en rises and is sampled at edge T, mode 0 → pulse high on edges T+1..T+width, low until T+period, then repeats.
- Simultaneous events:
  - en=0 beats a boundary or a done.
  - trig while RUN is ignored (no retrigger).
  - A config transfer on the same edge as the apply moment is held pending until the next boundary.
- Channels are fully independent. The config port serves one channel per cycle.
- Arithmetic: count is CNT_W bits, unsigned. Compares are unsigned; no overflow is possible because count < period_eff.
- rst_n asserted mid-period: all outputs drop immediately (async); shadow contents are lost.

Optional Feature:
- Macro: PULSE_GEN_PHASE_EN
- Defined:
  - Adds input cfg_phase [CNT_W], captured with the other shadow fields (reset 0).
  - On IDLE→RUN, count loads (phase mod period_eff) instead of 0, giving a per-channel start offset.
  - Wrap still goes to 0.
  - In one-shot mode, the shot ends at the first boundary, so it is shortened by the phase.
- Not defined: no cfg_phase port; start count is always 0.

Test Plan:
- Reset defaults: release rst_n, en=4'b0001 → ch0 pulse high 3 cycles, low 7, period 10; busy0=1; other channels pulse=0.
- Glitch-free update:
  - Stimulus: ch1 running 10/3; write cfg_ch=1, period=5, width=2 mid-period.
  - Required: cfg_ready=0 for ch1 until the boundary, current period completes as 10/3, next periods are 5/2.
  - Required: cfg_ready stays 1 when cfg_ch=2 during that window.
- One-shot:
  - Stimulus: ch2 mode=1, period=6, width=4; trig2 pulsed 1 cycle.
  - Required: pulse2 high 4, low 2, done2 one cycle at the end, then IDLE.
  - Required: a second trig during RUN has no effect.
- Boundary values: period=0,width=0 → pulse stays 0, busy=1, period 1; period=4,width=9 → pulse constant 1 while en.
- Disable/reset mid-operation:
  - Stimulus: en3 dropped at count=2 → next edge pulse3=0, busy3=0, no done.
  - Stimulus: async rst_n asserted mid-pulse between edges → all outputs 0 immediately; defaults restored.
- PULSE_GEN_PHASE_EN: two channels at 8/4, ch1 phase=4, enabled on the same edge → ch1 pulse is exactly the complement of ch0.

Source files
------------

// File: rtl/pulse_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_gen_multi
//  Purpose  : Multi-channel programmable pulse generator. Each channel has
//             its own period, high-time and mode (continuous / one-shot),
//             written through a valid/ready config port into shadow
//             registers that are applied only at a period boundary (or
//             while idle/disabled), so running waveforms never glitch.
//  Options  : `define PULSE_GEN_PHASE_EN adds a cfg_phase field that sets
//             a per-channel start offset on IDLE->RUN.
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_gen_multi #(
   parameter int NUM_CH         = 4,
   parameter int CNT_W          = 8,
   parameter int DEFAULT_PERIOD = 10,
   parameter int DEFAULT_WIDTH  = 3
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         cfg_valid,
   output logic                                         cfg_ready,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
   input  logic [CNT_W-1:0]                             cfg_period,
   input  logic [CNT_W-1:0]                             cfg_width,
   input  logic                                         cfg_mode,
`ifdef PULSE_GEN_PHASE_EN
   input  logic [CNT_W-1:0]                             cfg_phase,
`endif
   input  logic [NUM_CH-1:0]                            en,
   input  logic [NUM_CH-1:0]                            trig,
   output logic [NUM_CH-1:0]                            pulse,
   output logic [NUM_CH-1:0]                            busy,
   output logic [NUM_CH-1:0]                            done
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [CNT_W-1:0] C_DEF_PERIOD = CNT_W'(DEFAULT_PERIOD);
   localparam logic [CNT_W-1:0] C_DEF_WIDTH  = CNT_W'(DEFAULT_WIDTH);
   localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   logic [NUM_CH-1:0] w_pend_vec;
   logic              w_ready;

   // Ready is low only while the addressed channel still holds an unapplied
   // shadow; out-of-range channel numbers are always accepted and dropped.
   always_comb begin
      w_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if ((cfg_ch == CH_W'(i)) && w_pend_vec[i]) begin
            w_ready = 1'b0;
         end
      end
   end

   assign cfg_ready = w_ready;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      // FSM / output registers
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] r_count;
      logic [CNT_W-1:0] w_count_nxt;
      logic             r_pulse;
      logic             w_pulse_nxt;
      logic             r_busy;
      logic             w_busy_nxt;
      logic             r_done;
      logic             w_done_nxt;

      // Active and shadow configuration
      logic [CNT_W-1:0] r_period;
      logic [CNT_W-1:0] r_width;
      logic             r_mode;
      logic [CNT_W-1:0] r_sh_period;
      logic [CNT_W-1:0] r_sh_width;
      logic             r_sh_mode;
      logic             r_pend;

      // Configuration as it will be after this edge (shadow if applying)
      logic [CNT_W-1:0] w_period_eff;
      logic [CNT_W-1:0] w_period_n;
      logic [CNT_W-1:0] w_period_eff_n;
      logic [CNT_W-1:0] w_width_n;
      logic             w_mode_n;
      logic [CNT_W-1:0] w_start;
      logic [CNT_W-1:0] w_count_inc;
      logic             w_xfer;
      logic             w_boundary;
      logic             w_apply;

`ifdef PULSE_GEN_PHASE_EN
      logic [CNT_W-1:0] r_phase;
      logic [CNT_W-1:0] r_sh_phase;
      logic [CNT_W-1:0] w_phase_n;
`endif

      assign w_xfer       = cfg_valid && w_ready && (cfg_ch == CH_W'(gi));
      assign w_period_eff = (r_period == '0) ? C_ONE : r_period;
      assign w_boundary   = (r_state == ST_RUN) && (r_count == (w_period_eff - C_ONE));

      // Shadow moves to active while idle, at a run boundary, or when the
      // channel is being disabled (it is about to sit in IDLE anyway).
      assign w_apply = r_pend && ((r_state == ST_IDLE) || w_boundary || !en[gi]);

      assign w_period_n     = w_apply ? r_sh_period : r_period;
      assign w_width_n      = w_apply ? r_sh_width  : r_width;
      assign w_mode_n       = w_apply ? r_sh_mode   : r_mode;
      assign w_period_eff_n = (w_period_n == '0) ? C_ONE : w_period_n;
      assign w_count_inc    = r_count + C_ONE;

`ifdef PULSE_GEN_PHASE_EN
      assign w_phase_n = w_apply ? r_sh_phase : r_phase;
      assign w_start   = w_phase_n % w_period_eff_n;
`else
      assign w_start   = '0;
`endif

      // Next-state and registered-output logic; pulse is derived from the
      // next count so it stays aligned with the count register.
      always_comb begin
         w_state_nxt = r_state;
         w_count_nxt = r_count;
         w_pulse_nxt = 1'b0;
         w_busy_nxt  = 1'b0;
         w_done_nxt  = 1'b0;
         if (!en[gi]) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  w_count_nxt = '0;
                  if (!w_mode_n || trig[gi]) begin
                     w_state_nxt = ST_RUN;
                     w_count_nxt = w_start;
                     w_pulse_nxt = (w_start < w_width_n);
                     w_busy_nxt  = 1'b1;
                  end
               end
               ST_RUN: begin
                  if (w_boundary) begin
                     w_count_nxt = '0;
                     if (r_mode) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                     end else begin
                        w_pulse_nxt = (w_width_n != '0);
                        w_busy_nxt  = 1'b1;
                     end
                  end else begin
                     w_count_nxt = w_count_inc;
                     w_pulse_nxt = (w_count_inc < w_width_n);
                     w_busy_nxt  = 1'b1;
                  end
               end
               default: begin
                  w_state_nxt = ST_IDLE;
                  w_count_nxt = '0;
               end
            endcase
         end
      end

      // FSM state, counter and output registers
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_pulse <= w_pulse_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
         end
      end

      // Shadow capture from the config port and shadow-to-active transfer
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_sh_period <= C_DEF_PERIOD;
            r_sh_width  <= C_DEF_WIDTH;
            r_sh_mode   <= 1'b0;
            r_period    <= C_DEF_PERIOD;
            r_width     <= C_DEF_WIDTH;
            r_mode      <= 1'b0;
            r_pend      <= 1'b0;
         end else begin
            if (w_xfer) begin
               r_sh_period <= cfg_period;
               r_sh_width  <= cfg_width;
               r_sh_mode   <= cfg_mode;
               r_pend      <= 1'b1;
            end else if (w_apply) begin
               r_pend      <= 1'b0;
            end
            if (w_apply) begin
               r_period <= r_sh_period;
               r_width  <= r_sh_width;
               r_mode   <= r_sh_mode;
            end
         end
      end

`ifdef PULSE_GEN_PHASE_EN
      // Start-offset shadow and active copies follow the other fields
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_sh_phase <= '0;
            r_phase    <= '0;
         end else begin
            if (w_xfer) begin
               r_sh_phase <= cfg_phase;
            end
            if (w_apply) begin
               r_phase <= r_sh_phase;
            end
         end
      end
`endif

      assign w_pend_vec[gi] = r_pend;
      assign pulse[gi]      = r_pulse;
      assign busy[gi]       = r_busy;
      assign done[gi]       = r_done;
   end

endmodule
`default_nettype wire

// File: tb/tb_pulse_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_gen_multi
//  Purpose  : Directed self-checking bench for pulse_gen_multi (4 channels,
//             8-bit counters, default 10/3). Phase test active when
//             PULSE_GEN_PHASE_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_gen_multi;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [1:0]       cfg_ch;
   logic [CNT_W-1:0] cfg_period;
   logic [CNT_W-1:0] cfg_width;
   logic             cfg_mode;
`ifdef PULSE_GEN_PHASE_EN
   logic [CNT_W-1:0] cfg_phase;
`endif
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] trig;
   logic [NUM_CH-1:0] pulse;
   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] done;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pulse_gen_multi #(
      .NUM_CH         (NUM_CH),
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (10),
      .DEFAULT_WIDTH  (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_period (cfg_period),
      .cfg_width  (cfg_width),
      .cfg_mode   (cfg_mode),
`ifdef PULSE_GEN_PHASE_EN
      .cfg_phase  (cfg_phase),
`endif
      .en         (en),
      .trig       (trig),
      .pulse      (pulse),
      .busy       (busy),
      .done       (done)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      en        = '0;
      trig      = '0;
      cfg_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // One config transfer; returns 1 unit after the accepting edge
   task automatic cfg_write(input logic [1:0] ch, input logic [7:0] per,
                            input logic [7:0] wid, input logic md, input logic [7:0] ph);
      cfg_ch     = ch;
      cfg_period = per;
      cfg_width  = wid;
      cfg_mode   = md;
`ifdef PULSE_GEN_PHASE_EN
      cfg_phase  = ph;
`else
      if (ph != 8'd0) $display("note: phase ignored in this build");
`endif
      cfg_valid  = 1'b1;
      tick();
      cfg_valid  = 1'b0;
   endtask

   logic [31:0] pv, pv1, bv, dv, ov;

   initial begin
      rst_n      = 1'b0;
      cfg_valid  = 1'b0;
      cfg_ch     = 2'd0;
      cfg_period = '0;
      cfg_width  = '0;
      cfg_mode   = 1'b0;
`ifdef PULSE_GEN_PHASE_EN
      cfg_phase  = '0;
`endif
      en         = '0;
      trig       = '0;

      // ---------------- reset state and default waveform -----------------
      tick();
      tick();
      check("rst_pulse", 32'(pulse), 32'h0);
      check("rst_busy",  32'(busy),  32'h0);
      check("rst_done",  32'(done),  32'h0);
      check("rst_ready", 32'(cfg_ready), 32'h1);
      rst_n = 1'b1;
      en    = 4'b0001;
      pv = '0; bv = '0; ov = '0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         pv[k-1] = pulse[0];
         bv[k-1] = busy[0];
         ov      = ov | 32'(pulse[3:1]);
      end
      check("def_pulse0", pv, 32'h0001C07);
      check("def_busy0",  bv, 32'h00FFFFF);
      check("def_others", ov, 32'h0);

      // ---------------- glitch-free update on ch1 ------------------------
      do_reset();
      en = 4'b0010;
      pv = '0; bv = '0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         pv[k-1] = pulse[1];
         bv[k-1] = busy[1];
         if (k == 3) begin
            cfg_ch     = 2'd1;
            cfg_period = 8'd5;
            cfg_width  = 8'd2;
            cfg_mode   = 1'b0;
            cfg_valid  = 1'b1;
            #1;
            check("upd_ready_before", 32'(cfg_ready), 32'h1);
         end
         if (k == 4) begin
            cfg_valid = 1'b0;
            check("upd_ready_ch1_pend", 32'(cfg_ready), 32'h0);
            cfg_ch = 2'd2;
            #1;
            check("upd_ready_ch2", 32'(cfg_ready), 32'h1);
            cfg_ch = 2'd1;
         end
         if (k == 10) check("upd_ready_last_old", 32'(cfg_ready), 32'h0);
         if (k == 11) check("upd_ready_applied",  32'(cfg_ready), 32'h1);
      end
      check("upd_pulse1", pv, 32'h0018C07);
      check("upd_busy1",  bv, 32'h00FFFFF);

      // ---------------- one-shot on ch2 ----------------------------------
      do_reset();
      cfg_write(2'd2, 8'd6, 8'd4, 1'b1, 8'd0);
      tick();
      en = 4'b0100;
      tick();
      tick();
      check("os_idle_wait", 32'(busy[2]), 32'h0);
      trig = 4'b0100;
      pv = '0; bv = '0; dv = '0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) trig = 4'b0000;
         if (k == 2) trig = 4'b0100;
         if (k == 3) trig = 4'b0000;
         pv[k-1] = pulse[2];
         bv[k-1] = busy[2];
         dv[k-1] = done[2];
      end
      check("os_pulse2", pv, 32'h00F);
      check("os_busy2",  bv, 32'h03F);
      check("os_done2",  dv, 32'h040);

      // ---------------- boundary configs on ch3 --------------------------
      do_reset();
      cfg_write(2'd3, 8'd0, 8'd0, 1'b0, 8'd0);
      tick();
      en = 4'b1000;
      pv = '0; bv = '0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         pv[k-1] = pulse[3];
         bv[k-1] = busy[3];
      end
      check("p0w0_pulse", pv, 32'h00);
      check("p0w0_busy",  bv, 32'h3F);
      cfg_ch     = 2'd3;
      cfg_period = 8'd4;
      cfg_width  = 8'd9;
      cfg_mode   = 1'b0;
      cfg_valid  = 1'b1;
      pv = '0; bv = '0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) cfg_valid = 1'b0;
         pv[k-1] = pulse[3];
         bv[k-1] = busy[3];
      end
      check("p4w9_pulse", pv, 32'hFE);
      check("p4w9_busy",  bv, 32'hFF);

      // ---------------- disable mid-period on ch3 ------------------------
      do_reset();
      en = 4'b1000;
      dv = '0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 3) begin
            check("dis_pulse_before", 32'(pulse[3]), 32'h1);
            en = 4'b0000;
         end
         if (k == 4) begin
            check("dis_pulse_after", 32'(pulse[3]), 32'h0);
            check("dis_busy_after",  32'(busy[3]),  32'h0);
         end
         if (k >= 4) dv = dv | 32'(done[3]);
      end
      check("dis_no_done", dv, 32'h0);

      // ---------------- async reset mid-pulse ----------------------------
      do_reset();
      cfg_write(2'd0, 8'd5, 8'd1, 1'b0, 8'd0);
      tick();
      en = 4'b0001;
      tick();
      check("arst_pulse_before", 32'(pulse[0]), 32'h1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_pulse", 32'(pulse), 32'h0);
      check("arst_busy",  32'(busy),  32'h0);
      check("arst_done",  32'(done),  32'h0);
      tick();
      rst_n = 1'b1;
      pv = '0;
      for (int k = 1; k <= 13; k++) begin
         tick();
         pv[k-1] = pulse[0];
      end
      check("arst_defaults", pv, 32'h1C07);

`ifdef PULSE_GEN_PHASE_EN
      // ---------------- phase offset: ch1 complements ch0 ----------------
      do_reset();
      cfg_write(2'd0, 8'd8, 8'd4, 1'b0, 8'd0);
      cfg_write(2'd1, 8'd8, 8'd4, 1'b0, 8'd4);
      tick();
      en = 4'b0011;
      pv = '0; pv1 = '0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         pv[k-1]  = pulse[0];
         pv1[k-1] = pulse[1];
      end
      check("phase_ch0", pv,  32'h0F0F);
      check("phase_ch1", pv1, 32'hF0F0);
`else
      pv1 = '0;
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
